// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Raster timing generator for a VGA-style display. Produces the scan
// position (x, y), the display-enable window, the sync pulses, and
// one-cycle line/frame start markers.
// The scan is started by i_en. When i_en is dropped, the current frame
// is finished before the generator returns to idle.
// Every output is registered. Each output is computed from the same
// next-state position, so all outputs change on the same edge.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  X_W      = $clog2(H_TOTAL),
    localparam int  Y_W      = $clog2(V_TOTAL)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clk_en,
    input  logic           i_en,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_de,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_line_start,
    output logic           o_frame_start,
    output logic           o_running
);

    // Scan states. DRAIN keeps scanning normally, but stops at the end of the frame.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Last valid position on each axis.
    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

    // Window bounds get one extra bit. With a zero back porch, the sync end
    // can equal TOTAL, and that value does not fit in X_W/Y_W bits.
    localparam logic [X_W:0] X_DE_END = (X_W+1)'(H_ACTIVE);
    localparam logic [X_W:0] X_HS_BEG = (X_W+1)'(H_ACTIVE + H_FP);
    localparam logic [X_W:0] X_HS_END = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W:0] Y_DE_END = (Y_W+1)'(V_ACTIVE);
    localparam logic [Y_W:0] Y_VS_BEG = (Y_W+1)'(V_ACTIVE + V_FP);
    localparam logic [Y_W:0] Y_VS_END = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0]     r_state;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_hs;
    logic           r_vs;
    logic           r_de;
    logic           r_line_start;
    logic           r_frame_start;
    logic           r_running;

    logic [1:0]     w_state_next;
    logic [X_W-1:0] w_x_next;
    logic [Y_W-1:0] w_y_next;
    logic           w_scanning;
    logic           w_start;
    logic           w_x_wrap;
    logic           w_y_wrap;
    logic           w_frame_end;
    logic           w_next_active;
    logic           w_hs_next;
    logic           w_vs_next;
    logic           w_de_next;
    logic           w_line_start_next;
    logic           w_frame_start_next;

    // Decode the wrap points and the start condition from the current state.
    always_comb begin
        w_scanning  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_start     = (r_state == ST_IDLE) && i_en;
        w_x_wrap    = (r_x == X_LAST);
        w_y_wrap    = (r_y == Y_LAST);
        w_frame_end = w_x_wrap && w_y_wrap;
    end

    // Next state. Starting does not need a pixel tick. Stopping happens only on
    // the tick that leaves the last pixel of the frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                w_state_next = i_en ? ST_RUN : ST_IDLE;
            end
            ST_RUN, ST_DRAIN: begin
                if (i_clk_en && w_frame_end && !i_en) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = i_en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Next position. Idle pins the position at the origin. Scanning advances
    // one pixel per tick and wraps x, then y.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (!w_scanning) begin
            w_x_next = '0;
            w_y_next = '0;
        end else if (i_clk_en) begin
            if (w_x_wrap) begin
                w_x_next = '0;
                w_y_next = w_y_wrap ? '0 : (r_y + Y_W'(1));
            end else begin
                w_x_next = r_x + X_W'(1);
            end
        end
    end

    // Level outputs for the next position. Idle values apply whenever the
    // next state is idle.
    always_comb begin
        w_next_active = (w_state_next != ST_IDLE);
        w_de_next     = 1'b0;
        w_hs_next     = !HS_POL;
        w_vs_next     = !VS_POL;
        if (w_next_active) begin
            w_de_next = ({1'b0, w_x_next} < X_DE_END) &&
                        ({1'b0, w_y_next} < Y_DE_END);
            w_hs_next = (({1'b0, w_x_next} >= X_HS_BEG) &&
                         ({1'b0, w_x_next} <  X_HS_END)) ? HS_POL : !HS_POL;
            w_vs_next = (({1'b0, w_y_next} >= Y_VS_BEG) &&
                         ({1'b0, w_y_next} <  Y_VS_END)) ? VS_POL : !VS_POL;
        end
    end

    // Start markers. A marker fires only on the edge that first presents the
    // new line or frame, so held positions (no tick) never repeat it.
    always_comb begin
        w_line_start_next  = w_start ||
                             (w_scanning && i_clk_en && w_x_wrap && w_next_active);
        w_frame_start_next = w_start ||
                             (w_scanning && i_clk_en && w_frame_end && w_next_active);
    end

    // State, position and output registers. Reset forces idle values at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_hs          <= !HS_POL;
            r_vs          <= !VS_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hs          <= w_hs_next;
            r_vs          <= w_vs_next;
            r_de          <= w_de_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
            r_running     <= w_next_active;
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_de          = r_de;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_running     = r_running;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl using a small 8x6 raster.
// The reference model tracks a linear pixel index within the frame.
// The expected x, y, windows and sync levels are derived from that index arithmetically.
module tb_vga_timing_ctrl;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       clk_en = 1'b0;
    logic       en     = 1'b0;
    logic       hs, vs, de, ls, fs, running;
    logic [2:0] x, y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: scanning flag, pixel index 0..47, pulse flags.
    bit m_active = 1'b0;
    int m_p      = 0;
    bit m_ls     = 1'b0;
    bit m_fs     = 1'b0;

    vga_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clk_en     (clk_en),
        .i_en         (en),
        .o_hs         (hs),
        .o_vs         (vs),
        .o_de         (de),
        .o_x          (x),
        .o_y          (y),
        .o_line_start (ls),
        .o_frame_start(fs),
        .o_running    (running)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Expected outputs in the order {x, y, de, hs, vs, line_start, frame_start, running}.
    function automatic logic [11:0] exp_vec();
        int  mx = m_p % 8;
        int  my = m_p / 8;
        bit  e_de = m_active && (mx < 4) && (my < 3);
        bit  e_hs = !(m_active && (mx == 5 || mx == 6));
        bit  e_vs = !(m_active && (my == 4));
        return {3'(mx), 3'(my), e_de, e_hs, e_vs, m_ls, m_fs, m_active};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {x, y, de, hs, vs, ls, fs, running};
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_p = 0; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit c);
        m_ls = 1'b0; m_fs = 1'b0;
        if (!m_active) begin
            if (e) begin m_active = 1'b1; m_p = 0; m_ls = 1'b1; m_fs = 1'b1; end
        end else if (c) begin
            if (m_p == 47) begin
                m_p = 0;
                if (!e) m_active = 1'b0;
                else begin m_ls = 1'b1; m_fs = 1'b1; end
            end else begin
                m_p++;
                if (m_p % 8 == 0) m_ls = 1'b1;
            end
        end
    endtask

    // Drive inputs at the falling edge, clock once, sample at the next falling edge.
    task automatic step(input bit e, input bit c);
        en = e; clk_en = c;
        @(posedge clk);
        model_edge(e, c);
        cyc++;
        @(negedge clk);
    endtask

    task automatic go_idle();
        for (int i = 0; i < 100 && m_active; i++) step(1'b0, 1'b1);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL go_idle: running=%b expected 0", running);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (x !== 3'd0)     begin errors++; $display("FAIL reset_x: got %0d expected 0", x); end
        checks++; if (y !== 3'd0)     begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
        checks++; if (de !== 1'b0)    begin errors++; $display("FAIL reset_de: got %b expected 0", de); end
        checks++; if (hs !== 1'b1)    begin errors++; $display("FAIL reset_hs: got %b expected 1", hs); end
        checks++; if (vs !== 1'b1)    begin errors++; $display("FAIL reset_vs: got %b expected 1", vs); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++; if ({ls, fs} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {ls, fs}); end
        $display("reset: x=%0d y=%0d de=%b hs=%b vs=%b running=%b", x, y, de, hs, vs, running);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        int last_ls = -1, last_fs = -1;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL free_run: got %h expected %h at step %0d", obs_vec(), exp_vec(), i);
            end
            if (ls) begin
                if (last_ls >= 0) begin
                    checks++;
                    if (cyc - last_ls != 8) begin errors++; $display("FAIL free_run_ls_period: got %0d expected 8", cyc - last_ls); end
                end
                last_ls = cyc;
            end
            if (fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != 48) begin errors++; $display("FAIL free_run_fs_period: got %0d expected 48", cyc - last_fs); end
                end
                last_fs = cyc;
            end
        end
        $display("free_run: ended at x=%0d y=%0d", x, y);
        go_idle();
    endtask

    task automatic test_clk_en_div();
        int last_fs = -1;
        for (int k = 0; k < 450; k++) begin
            step(1'b1, (k % 3) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clk_en_div: got %h expected %h at step %0d", obs_vec(), exp_vec(), k);
            end
            if (fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != 144) begin errors++; $display("FAIL clk_en_fs_period: got %0d expected 144", cyc - last_fs); end
                end
                last_fs = cyc;
            end
        end
        $display("clk_en_div: ended at x=%0d y=%0d", x, y);
        go_idle();
    endtask

    task automatic test_drain();
        logic [2:0] px, py;
        bit         fell = 1'b0;
        for (int i = 0; i < 60 && !(m_active && m_p == 10); i++) step(1'b1, 1'b1);
        for (int i = 0; i < 100 && !fell; i++) begin
            px = x; py = y;
            step(1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_scan: got %h expected %h", obs_vec(), exp_vec());
            end
            if (running === 1'b0) fell = 1'b1;
        end
        checks++;
        if (!fell || px !== 3'd7 || py !== 3'd5) begin
            errors++;
            $display("FAIL drain_exit: fell=%b last=(%0d,%0d) expected exit after (7,5)", fell, px, py);
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (fs !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL drain_idle: fs=%b running=%b expected 0 0", fs, running);
            end
        end
        $display("drain: exited after (%0d,%0d)", px, py);
    endtask

    task automatic test_drain_resume();
        int  fs_cyc = -1;
        bit  dropped = 1'b0, got = 1'b0;
        step(1'b1, 1'b1);
        if (fs) fs_cyc = cyc;
        for (int i = 0; i < 60 && m_p != 10; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 60 && m_p != 24; i++) begin
            step(1'b0, 1'b1);
            if (running !== 1'b1) dropped = 1'b1;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resume_scan: got %h expected %h", obs_vec(), exp_vec());
            end
            if (running !== 1'b1) dropped = 1'b1;
            if (fs === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || fs_cyc < 0 || cyc - fs_cyc != 48) begin
            errors++;
            $display("FAIL resume_fs_period: got %0d expected 48 (seen=%b)", cyc - fs_cyc, got);
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL resume_running: running dropped, expected stay 1"); end
        $display("drain_resume: frame_start interval %0d", cyc - fs_cyc);
        go_idle();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 60 && !(m_active && m_p == 10); i++) step(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_midframe: got %h expected %h", obs_vec(), exp_vec());
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || fs !== 1'b1 || x !== 3'd0 || y !== 3'd0) begin
            errors++;
            $display("FAIL reset_rerun: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("reset_midframe: restarted at (%0d,%0d) fs=%b", x, y, fs);
        go_idle();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random: got %h expected %h at step %0d", obs_vec(), exp_vec(), i);
            end
        end
        $display("random: 2000 steps, %0d differences", bad);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_clk_en_div();
        test_drain();
        test_drain_resume();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line SHALL be set by this parameter.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels SHALL be set by this parameter.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels SHALL be set by this parameter.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels SHALL be set by this parameter.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, SHALL be the vertical equivalents in lines.
REQ-006 Parameters HS_POL/VS_POL, default 0/0, SHALL be the sync levels while the sync pulse is active.
REQ-007 Derived widths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; X_W = $clog2(H_TOTAL); V_TOTAL and Y_W SHALL be derived the same way.
REQ-008 clk  in  1  the single clock; all state SHALL be on posedge clk.
REQ-009 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-010 clk_en  in  1  pixel tick; counters SHALL advance only on clk edges with clk_en=1.
REQ-011 en  in  1  run request; 1 = start/keep scanning, 0 = stop at end of frame.
REQ-012 hs / vs  out  1  horizontal / vertical sync.
REQ-013 de  out  1  display enable, 1 inside the active area.
REQ-014 x  out  X_W  current horizontal position; y  out  Y_W  current line.
REQ-015 line_start / frame_start  out  1  one-clk pulses that mark a new line / new frame.
REQ-016 running  out  1  1 in RUN or DRAIN.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 IDLE: x=y=0, de=0, hs=!HS_POL, vs=!VS_POL, pulses 0, running=0.
REQ-019 IDLE->RUN SHALL occur on any clk edge with en=1, whatever the value of clk_en.
REQ-020 The first RUN cycle SHALL present (0,0) with frame_start=1 and line_start=1.
REQ-021 In RUN/DRAIN, each clk_en tick SHALL increment x; x=H_TOTAL-1 SHALL wrap to 0 and increment y; y=V_TOTAL-1 with x wrap SHALL wrap y to 0.
REQ-022 Without clk_en, position and all level outputs SHALL hold.
REQ-023 line_start SHALL be 1 for exactly one clk cycle: the first cycle in which x=0 is presented after a wrap.
REQ-024 frame_start SHALL be 1 for exactly one clk cycle: the first cycle in which (0,0) is presented after a wrap.
REQ-025 de SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-026 hs SHALL equal HS_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, and !HS_POL otherwise.
REQ-027 vs SHALL equal VS_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, and !VS_POL otherwise.
REQ-028 All outputs SHALL be registered and cycle-aligned to x/y, with zero offset between them.
REQ-029 en=0 in RUN SHALL move the FSM to DRAIN; DRAIN SHALL scan normally.
REQ-030 DRAIN SHALL move to IDLE on the clk_en tick leaving (H_TOTAL-1, V_TOTAL-1); no frame_start SHALL be emitted at that point.
REQ-031 en=1 in DRAIN SHALL return the FSM to RUN with no position disturbance; frame_start SHALL then occur at the normal wrap.
REQ-032 If en=0 on the same edge as the IDLE->RUN check, the FSM SHALL stay in IDLE.
REQ-033 Counter arithmetic SHALL be unsigned and compare against the parameters only; x and y SHALL never exceed TOTAL-1.

Reset
REQ-034 rst=0 SHALL force IDLE and the REQ-018 output values immediately, without waiting for a clk edge, including mid-frame.
REQ-035 After rst release with en=1, the first RUN cycle SHALL follow REQ-020.

Verification
All scenarios use H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), polarity 0/0.
REQ-036 Reset: rst=0 with no clk -> x=y=0, de=0, hs=vs=1, running=0.
REQ-037 en=1, clk_en=1 -> hs=0 at x=5,6; de=1 at x=0..3 for y=0..2; vs=0 at y=4; line_start every 8 clks; frame_start every 48 clks.
REQ-038 clk_en high 1 clk in 3 -> each position held 3 clks; each pulse still 1 clk wide; frame_start period 144 clks.
REQ-039 en drops at (2,1) -> scan continues to (7,5), then IDLE, running=0, no further frame_start.
REQ-040 en drops at (2,1) and rises at (0,3) -> no IDLE entry; frame_start at the next (0,0) exactly 48 clks after the previous one.
REQ-041 rst pulsed low at (2,1) between clk edges -> outputs at IDLE values at once; re-run after release starts at (0,0) with frame_start.
